id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register for the 5-stage MIPS core. Fed directly by the decode-stage
//  Control unit's 10-bit control word, plus the register-file and sign-extend outputs.
//  Detects load-use hazards and inserts a one-cycle bubble into EX while telling PC/IF-ID to hold.
//  Also honours a squash request and keeps a saturating stall counter for performance reporting.
// PARAMETERS
//  DATA_W  32  width of register operands and the sign-extended immediate
//  REG_AW  5   register address width
//  CTRL_W  10  control word width
//  CNT_W   16  stall counter width
// PORTS
//  clk_i          in   1       clock; all state updates on the rising edge
//  rst_i          in   1       reset; asynchronous, active-high
//  ctrl_i         in   CTRL_W  Control word {ALUOp[9:8],RegDst,ALUSrc,MemtoReg,RegWrite,MemWrite,MemRead,Branch,Jump}
//  flush_i        in   1       squash the instruction currently in ID
//  rs_data_i      in   DATA_W  register-file read data, port rs
//  rt_data_i      in   DATA_W  register-file read data, port rt
//  imm_i          in   DATA_W  sign-extended immediate (imm_i[5:0] carries funct)
//  rs_addr_i      in   REG_AW  instruction rs field
//  rt_addr_i      in   REG_AW  instruction rt field
//  rd_addr_i      in   REG_AW  instruction rd field
//  stall_o        out  1       combinational; hold PC and IF/ID this cycle
//  ex_alu_op_o    out  2       registered ALUOp
//  ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o, ex_mem_write_o, ex_mem_read_o
//                 out  1 each  registered control bits
//  ex_rs_data_o   out  DATA_W  registered rs data
//  ex_rt_data_o   out  DATA_W  registered rt data
//  ex_imm_o       out  DATA_W  registered immediate
//  ex_rs_addr_o   out  REG_AW  registered rs field
//  ex_rt_addr_o   out  REG_AW  registered rt field
//  ex_rd_addr_o   out  REG_AW  registered rd field
//  ex_valid_o     out  1       1 = real instruction in EX; 0 = bubble
//  stall_cnt_o    out  CNT_W   number of hazard bubbles inserted, saturating
// BEHAVIOUR
//  - Reset: every registered output is 0, including ex_valid_o and stall_cnt_o. ID/EX then holds a bubble.
//  - Hazard: hz = ex_mem_read_o & ex_valid_o & (ex_rt_addr_o != 0) &
//    ((ex_rt_addr_o == rs_addr_i) | (ex_rt_addr_o == rt_addr_i)).
//  - stall_o = hz & ~flush_i. A squashed instruction never stalls.
//  - Per-edge priority: rst_i > flush_i > hz > normal load.
//  - flush_i or hz: the six control bits, ALUOp and ex_valid_o load 0. Data and address
//    fields load their inputs but are don't-care while ex_valid_o = 0.
//  - Normal: every field loads from its input; ex_valid_o loads 1. Latency ID to EX is 1 cycle.
//  - Branch and Jump (ctrl_i[1:0]) resolve in ID and are not propagated.
//  - stall_cnt_o increments on each edge where stall_o = 1 and saturates at 2^CNT_W-1.
//    It does not wrap and counts nothing for flush_i.
//  - Stall length is exactly 1 cycle: after the bubble, ex_mem_read_o = 0, so hz drops.
//  - Reset asserted mid-stall clears everything asynchronously; stall_o deasserts immediately.
// STRUCTURE
//  - Shared package/header cpu_defs: CTRL_* bit-index localparams (ALUOP_HI=9, ALUOP_LO=8,
//    REGDST=7, ALUSRC=6, MEMTOREG=5, REGWRITE=4, MEMWRITE=3, MEMREAD=2, BRANCH=1, JUMP=0),
//    and ALUOP_ADD/SUB/OR/RTYPE = 2'b00/01/10/11.
//  - One combinational sub-module, hazard_detect: produces hz from the EX and ID fields above.
//  - Pipeline registers and the counter live in id_ex_stage.
// TESTING
//  1. Reset with rst_i=1 mid-run -> all outputs 0 immediately; stall_o=0.
//  2. addi $1,$0,5 (ctrl 0x050) -> next edge: ex_alu_src_o=1, ex_reg_write_o=1,
//     ex_imm_o=5, ex_valid_o=1, stall_o=0.
//  3. lw $2,0($0) then add $3,$2,$4 -> stall_o=1 for 1 cycle; EX gets a bubble (valid=0);
//     add enters EX next cycle; stall_cnt_o=1.
//  4. lw $0,0($0) then add $3,$0,$4 -> no stall.
//     lw $2 then addi $5,$6,1 (rs=6, rt=5) -> no stall.
//  5. lw $2 followed by add using $2, with flush_i=1 -> stall_o=0; bubble inserted;
//     stall_cnt_o unchanged.
//  6. Force 70000 back-to-back hazards (CNT_W=16) -> stall_cnt_o holds at 0xFFFF.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared definitions for the 5-stage MIPS core: control-word bit positions,
// ALUOp encodings and the EX-stage control bundle carried through ID/EX.
package cpu_defs;

  localparam int CTRL_W_DEF     = 10;
  localparam int CTRL_ALUOP_HI  = 9;
  localparam int CTRL_ALUOP_LO  = 8;
  localparam int CTRL_REGDST    = 7;
  localparam int CTRL_ALUSRC    = 6;
  localparam int CTRL_MEMTOREG  = 5;
  localparam int CTRL_REGWRITE  = 4;
  localparam int CTRL_MEMWRITE  = 3;
  localparam int CTRL_MEMREAD   = 2;
  localparam int CTRL_BRANCH    = 1;
  localparam int CTRL_JUMP      = 0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_OR    = 2'b10;
  localparam logic [1:0] ALUOP_RTYPE = 2'b11;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
  } ex_ctrl_t;

  // Branch and Jump are resolved in ID, so only the upper eight bits travel on.
  function automatic ex_ctrl_t to_ex_ctrl(input logic [CTRL_W_DEF-1:CTRL_MEMREAD] c);
    ex_ctrl_t r;
    r.alu_op     = c[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    r.reg_dst    = c[CTRL_REGDST];
    r.alu_src    = c[CTRL_ALUSRC];
    r.mem_to_reg = c[CTRL_MEMTOREG];
    r.reg_write  = c[CTRL_REGWRITE];
    r.mem_write  = c[CTRL_MEMWRITE];
    r.mem_read   = c[CTRL_MEMREAD];
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a valid load in EX whose destination (rt, non-zero)
// is read by the instruction currently in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_mem_read_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rt_addr_i,
  input  logic [REG_AW-1:0] id_rs_addr_i,
  input  logic [REG_AW-1:0] id_rt_addr_i,
  output logic              hz_o
);

  assign hz_o = ex_mem_read_i & ex_valid_i & (ex_rt_addr_i != '0) &
                ((ex_rt_addr_i == id_rs_addr_i) | (ex_rt_addr_i == id_rt_addr_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, squash handling
// and a saturating count of inserted hazard bubbles.
module id_ex_stage
  import cpu_defs::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] rs_data_i,
  input  logic [DATA_W-1:0] rt_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] rs_addr_i,
  input  logic [REG_AW-1:0] rt_addr_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  output logic              stall_o,
  output logic [1:0]        ex_alu_op_o,
  output logic              ex_reg_dst_o,
  output logic              ex_alu_src_o,
  output logic              ex_mem_to_reg_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_read_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [REG_AW-1:0] ex_rs_addr_o,
  output logic [REG_AW-1:0] ex_rt_addr_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_valid_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  ex_ctrl_t          ctrl_q, ctrl_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rs_data_q, rt_data_q, imm_q;
  logic [REG_AW-1:0] rs_addr_q, rt_addr_q, rd_addr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hz;
  logic              unused_branch_jump;

  assign unused_branch_jump = |ctrl_i[CTRL_BRANCH:CTRL_JUMP];

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_valid_i    (valid_q),
    .ex_rt_addr_i  (rt_addr_q),
    .id_rs_addr_i  (rs_addr_i),
    .id_rt_addr_i  (rt_addr_i),
    .hz_o          (hz)
  );

  // A squashed instruction is discarded anyway, so it must not hold the front end.
  assign stall_o = hz & ~flush_i;

  always_comb begin
    ctrl_d  = '0;
    valid_d = 1'b0;
    cnt_d   = cnt_q;
    if (!(flush_i || hz)) begin
      ctrl_d  = to_ex_ctrl(ctrl_i[CTRL_W_DEF-1:CTRL_MEMREAD]);
      valid_d = 1'b1;
    end
    if (stall_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q    <= '0;
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      valid_q   <= valid_d;
      rs_data_q <= rs_data_i;
      rt_data_q <= rt_data_i;
      imm_q     <= imm_i;
      rs_addr_q <= rs_addr_i;
      rt_addr_q <= rt_addr_i;
      rd_addr_q <= rd_addr_i;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_alu_op_o     = ctrl_q.alu_op;
  assign ex_reg_dst_o    = ctrl_q.reg_dst;
  assign ex_alu_src_o    = ctrl_q.alu_src;
  assign ex_mem_to_reg_o = ctrl_q.mem_to_reg;
  assign ex_reg_write_o  = ctrl_q.reg_write;
  assign ex_mem_write_o  = ctrl_q.mem_write;
  assign ex_mem_read_o   = ctrl_q.mem_read;
  assign ex_rs_data_o    = rs_data_q;
  assign ex_rt_data_o    = rt_data_q;
  assign ex_imm_o        = imm_q;
  assign ex_rs_addr_o    = rs_addr_q;
  assign ex_rt_addr_o    = rt_addr_q;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_valid_o      = valid_q;
  assign stall_cnt_o     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed instruction table, mid-stall reset, and a
// randomized run against a pipeline-level reference model.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  ctrl_i;
  logic        flush_i;
  logic [31:0] rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;

  logic        stall_o, s_stall_o;
  logic [1:0]  ex_alu_op_o, s_alu_op;
  logic        ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o, ex_reg_write_o;
  logic        ex_mem_write_o, ex_mem_read_o, ex_valid_o;
  logic        s_reg_dst, s_alu_src, s_mem_to_reg, s_reg_write, s_mem_write, s_mem_read, s_valid;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, s_rs_data, s_rt_data, s_imm;
  logic [4:0]  ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o, s_rs_addr, s_rt_addr, s_rd_addr;
  logic [15:0] stall_cnt_o;
  logic [2:0]  s_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .flush_i(flush_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .stall_o(stall_o), .ex_alu_op_o(ex_alu_op_o), .ex_reg_dst_o(ex_reg_dst_o),
    .ex_alu_src_o(ex_alu_src_o), .ex_mem_to_reg_o(ex_mem_to_reg_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_rs_data_o(ex_rs_data_o),
    .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o), .ex_rs_addr_o(ex_rs_addr_o),
    .ex_rt_addr_o(ex_rt_addr_o), .ex_rd_addr_o(ex_rd_addr_o),
    .ex_valid_o(ex_valid_o), .stall_cnt_o(stall_cnt_o)
  );

  // Narrow counter copy so saturation is reached in a short run.
  id_ex_stage #(.CNT_W(3)) dut_sat (
    .clk_i(clk_i), .rst_i(rst_i), .ctrl_i(ctrl_i), .flush_i(flush_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .stall_o(s_stall_o), .ex_alu_op_o(s_alu_op), .ex_reg_dst_o(s_reg_dst),
    .ex_alu_src_o(s_alu_src), .ex_mem_to_reg_o(s_mem_to_reg),
    .ex_reg_write_o(s_reg_write), .ex_mem_write_o(s_mem_write),
    .ex_mem_read_o(s_mem_read), .ex_rs_data_o(s_rs_data),
    .ex_rt_data_o(s_rt_data), .ex_imm_o(s_imm), .ex_rs_addr_o(s_rs_addr),
    .ex_rt_addr_o(s_rt_addr), .ex_rd_addr_o(s_rd_addr),
    .ex_valid_o(s_valid), .stall_cnt_o(s_cnt)
  );

  function automatic logic [7:0] ex_ctrl_now();
    return {ex_alu_op_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_to_reg_o,
            ex_reg_write_o, ex_mem_write_o, ex_mem_read_o};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [31:0] imm, input logic fl,
                       input logic [31:0] rsd, input logic [31:0] rtd);
    ctrl_i = c; rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd; imm_i = imm;
    flush_i = fl; rs_data_i = rsd; rt_data_i = rtd;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [9:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm;
    logic        flush;
    logic        exp_stall;
    logic        exp_valid;
    logic [7:0]  exp_ctrl;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic [9:0] c, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] imm, input logic fl,
                              input logic st, input logic v, input logic [7:0] ec,
                              input logic [15:0] cnt);
    vec_t r;
    r.ctrl = c; r.rs = rs; r.rt = rt; r.rd = rd; r.imm = imm; r.flush = fl;
    r.exp_stall = st; r.exp_valid = v; r.exp_ctrl = ec; r.exp_cnt = cnt;
    return r;
  endfunction

  // ---------------- reference model state ----------------
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  int          m_stalls;

  function automatic logic model_hazard(input logic [4:0] rs, input logic [4:0] rt);
    // A load in EX writes its rt; ID must wait if it reads that register.
    return m_valid && m_ctrl[0] && (m_rt != 0) && (m_rt == rs || m_rt == rt);
  endfunction

  initial begin
    logic [9:0]  c;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm, rsd, rtd;
    logic        fl, exp_st;

    vecs[0]  = mk(10'h050, 5'd0, 5'd1, 5'd0, 32'd5,    1'b0, 1'b0, 1'b1, 8'h14, 16'd0); // addi $1,$0,5
    vecs[1]  = mk(10'h074, 5'd0, 5'd2, 5'd0, 32'd0,    1'b0, 1'b0, 1'b1, 8'h1D, 16'd0); // lw $2
    vecs[2]  = mk(10'h390, 5'd2, 5'd4, 5'd3, 32'h20,   1'b0, 1'b1, 1'b0, 8'h00, 16'd1); // add uses $2
    vecs[3]  = mk(10'h390, 5'd2, 5'd4, 5'd3, 32'h20,   1'b0, 1'b0, 1'b1, 8'hE4, 16'd1); // add re-issued
    vecs[4]  = mk(10'h074, 5'd0, 5'd0, 5'd0, 32'd0,    1'b0, 1'b0, 1'b1, 8'h1D, 16'd1); // lw $0
    vecs[5]  = mk(10'h390, 5'd0, 5'd4, 5'd3, 32'h20,   1'b0, 1'b0, 1'b1, 8'hE4, 16'd1); // add $3,$0,$4
    vecs[6]  = mk(10'h074, 5'd0, 5'd2, 5'd0, 32'd0,    1'b0, 1'b0, 1'b1, 8'h1D, 16'd1); // lw $2
    vecs[7]  = mk(10'h050, 5'd6, 5'd5, 5'd0, 32'd1,    1'b0, 1'b0, 1'b1, 8'h14, 16'd1); // addi $5,$6,1
    vecs[8]  = mk(10'h074, 5'd0, 5'd2, 5'd0, 32'd0,    1'b0, 1'b0, 1'b1, 8'h1D, 16'd1); // lw $2
    vecs[9]  = mk(10'h390, 5'd2, 5'd4, 5'd3, 32'h20,   1'b1, 1'b0, 1'b0, 8'h00, 16'd1); // squashed add
    vecs[10] = mk(10'h053, 5'd0, 5'd1, 5'd0, 32'd5,    1'b0, 1'b0, 1'b1, 8'h14, 16'd1); // branch/jump dropped

    // Reset state
    rst_i = 1'b1;
    drive(10'h3FF, 5'd1, 5'd1, 5'd1, 32'hFFFF_FFFF, 1'b0, 32'hA, 32'hB);
    repeat (2) @(posedge clk_i);
    #1;
    check("reset_valid", {31'd0, ex_valid_o}, 32'd0);
    check("reset_ctrl", {24'd0, ex_ctrl_now()}, 32'd0);
    check("reset_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("reset_imm", ex_imm_o, 32'd0);
    check("reset_stall", {31'd0, stall_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].flush,
            32'h1000 + i, 32'h2000 + i);
      #1;
      check($sformatf("v%0d_stall", i), {31'd0, stall_o}, {31'd0, vecs[i].exp_stall});
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, ex_valid_o}, {31'd0, vecs[i].exp_valid});
      check($sformatf("v%0d_ctrl", i), {24'd0, ex_ctrl_now()}, {24'd0, vecs[i].exp_ctrl});
      check($sformatf("v%0d_cnt", i), {16'd0, stall_cnt_o}, {16'd0, vecs[i].exp_cnt});
      if (vecs[i].exp_valid) begin
        check($sformatf("v%0d_imm", i), ex_imm_o, vecs[i].imm);
        check($sformatf("v%0d_rsd", i), ex_rs_data_o, 32'h1000 + i);
        check($sformatf("v%0d_rd", i), {27'd0, ex_rd_addr_o}, {27'd0, vecs[i].rd});
      end
      @(negedge clk_i);
    end

    // Reset asserted in the middle of a load-use stall
    drive(10'h074, 5'd0, 5'd7, 5'd0, 32'd4, 1'b0, 32'd0, 32'd0);
    @(posedge clk_i);
    @(negedge clk_i);
    drive(10'h390, 5'd7, 5'd4, 5'd3, 32'h20, 1'b0, 32'd1, 32'd2);
    #1;
    check("midrst_pre_stall", {31'd0, stall_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("midrst_stall", {31'd0, stall_o}, 32'd0);
    check("midrst_valid", {31'd0, ex_valid_o}, 32'd0);
    check("midrst_memread", {31'd0, ex_mem_read_o}, 32'd0);
    check("midrst_cnt", {16'd0, stall_cnt_o}, 32'd0);
    check("midrst_rt", {27'd0, ex_rt_addr_o}, 32'd0);
    check("midrst_sat_cnt", {29'd0, s_cnt}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Randomized run against the model
    m_valid = 1'b0; m_ctrl = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_stalls = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      c   = 10'($urandom);
      c[2] = ($urandom_range(0, 1) == 1);
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      rd  = 5'($urandom_range(0, 31));
      imm = $urandom; rsd = $urandom; rtd = $urandom;
      fl  = ($urandom_range(0, 7) == 0);
      drive(c, rs, rt, rd, imm, fl, rsd, rtd);
      #1;
      exp_st = model_hazard(rs, rt) && !fl;
      check("rand_stall", {31'd0, stall_o}, {31'd0, exp_st});
      @(posedge clk_i);
      if (exp_st) m_stalls++;
      if (fl || model_hazard(rs, rt)) begin
        m_valid = 1'b0; m_ctrl = '0;
      end else begin
        m_valid = 1'b1; m_ctrl = c[9:2];
      end
      m_rs = rs; m_rt = rt; m_rd = rd; m_imm = imm; m_rsd = rsd; m_rtd = rtd;
      #1;
      check("rand_valid", {31'd0, ex_valid_o}, {31'd0, m_valid});
      check("rand_ctrl", {24'd0, ex_ctrl_now()}, {24'd0, m_ctrl});
      check("rand_cnt", {16'd0, stall_cnt_o}, (m_stalls > 65535) ? 32'd65535 : m_stalls);
      check("rand_sat_cnt", {29'd0, s_cnt}, (m_stalls > 7) ? 32'd7 : m_stalls);
      if (m_valid) begin
        check("rand_rsd", ex_rs_data_o, m_rsd);
        check("rand_rtd", ex_rt_data_o, m_rtd);
        check("rand_imm", ex_imm_o, m_imm);
        check("rand_addr", {17'd0, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o},
              {17'd0, m_rs, m_rt, m_rd});
      end
      @(negedge clk_i);
    end
    if (m_stalls < 8) begin
      n_checks++;
      n_errors++;
      $display("FAIL rand_coverage: got %0d stalls, expected at least 8", m_stalls);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
